// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and the
// bit positions of the per-stage enable vector.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StIdle    = 3'd1,
    StStep    = 3'd2,
    StMemWait = 3'd3,
    StHalted  = 3'd4
  } ctrl_state_e;

  // Enable-vector bit positions, PC first, then the pipeline registers in order
  localparam int unsigned EnPc    = 0;
  localparam int unsigned EnIfid  = 1;
  localparam int unsigned EnIdex  = 2;
  localparam int unsigned EnExmem = 3;
  localparam int unsigned EnMemwb = 4;
  localparam int unsigned EnWidth = 5;

  typedef logic [EnWidth-1:0] en_vec_t;

  // State entered when leaving reset or HALTED: debug step mode parks in IDLE
  function automatic ctrl_state_e resume_state(input logic step_mode);
    return step_mode ? StIdle : StRun;
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction in ID. Register 0 never creates a dependency.
module hazard_detect_unit #(
  parameter int unsigned RBITS = 5
) (
  input  logic [RBITS-1:0] id_rs_i,
  input  logic [RBITS-1:0] id_rt_i,
  input  logic [RBITS-1:0] ex_rt_i,
  input  logic             ex_memread_i,
  output logic             stall_o
);

  // Stall when the load destination matches either ID source operand
  always_comb begin
    stall_o = ex_memread_i && (ex_rt_i != '0) &&
              ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencing controller. Produces PC / pipeline-register enables and
// flushes from load-use hazards, taken branches, data-memory wait states and
// debug run/step/halt control. Only state, wait counter, return state, the
// timeout flag and the cycle counter are registered; strobes are combinational.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RBITS   = 5,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CBITS   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [RBITS-1:0] i_id_rs,
  input  logic [RBITS-1:0] i_id_rt,
  input  logic [RBITS-1:0] i_ex_rt,
  input  logic             i_ex_memread,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_memread,
  input  logic             i_mem_memwrite,
  input  logic             i_dmem_ack,
  input  logic             i_wb_halt,
  input  logic             i_dbg_step_mode,
  input  logic             i_dbg_step,
  input  logic             i_dbg_resume,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_dmem_req,
  output logic             o_halted,
  output logic             o_err_timeout,
  output logic [CBITS-1:0] o_cycle_count
);

  localparam int unsigned WBITS = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  ctrl_state_e      state_q, state_d;
  ctrl_state_e      ret_q, ret_d;
  logic [WBITS-1:0] wait_q, wait_d;
  logic [WBITS-1:0] wait_inc;
  logic             err_q, err_d;
  logic [CBITS-1:0] cnt_q, cnt_d;

  en_vec_t          en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             dmem_req;
  logic             advance;
  logic             mem_access;
  logic             load_use;

  hazard_detect_unit #(
    .RBITS(RBITS)
  ) u_hazard (
    .id_rs_i      (i_id_rs),
    .id_rt_i      (i_id_rt),
    .ex_rt_i      (i_ex_rt),
    .ex_memread_i (i_ex_memread),
    .stall_o      (load_use)
  );

  assign mem_access = i_mem_memread | i_mem_memwrite;
  assign wait_inc   = wait_q + 1'b1;

  // Next-state selection: memory stall beats halt, halt beats step/run sequencing
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    wait_d   = wait_q;
    err_d    = err_q;
    dmem_req = 1'b0;
    advance  = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        StRun, StStep: begin
          dmem_req = mem_access;
          if (mem_access && !i_dmem_ack) begin
            // A step that stalls still ends in IDLE once the access completes
            state_d = StMemWait;
            ret_d   = (state_q == StRun) ? StRun : StIdle;
          end else begin
            advance = 1'b1;
            if (i_wb_halt) begin
              state_d = StHalted;
            end else if ((state_q == StStep) || i_dbg_step_mode) begin
              state_d = StIdle;
            end else begin
              state_d = StRun;
            end
          end
        end
        StMemWait: begin
          dmem_req = 1'b1;
          if (i_dmem_ack) begin
            // The deferred advance completes now, including a pending halt
            advance = 1'b1;
            wait_d  = '0;
            state_d = i_wb_halt ? StHalted : ret_q;
          end else if (wait_inc == WBITS'(TIMEOUT)) begin
            wait_d  = '0;
            err_d   = 1'b1;
            state_d = StHalted;
          end else begin
            wait_d  = wait_inc;
          end
        end
        StIdle: begin
          if (!i_dbg_step_mode) begin
            state_d = StRun;
          end else if (i_dbg_step) begin
            state_d = StStep;
          end
        end
        StHalted: begin
          if (i_dbg_resume) begin
            state_d = resume_state(i_dbg_step_mode);
          end
        end
        default: begin
          state_d = resume_state(i_dbg_step_mode);
        end
      endcase
    end
  end

  // Enable/flush pattern for an advancing cycle; branch squashes take priority
  // over the load-use bubble since the dependent instruction is discarded anyway
  always_comb begin
    en         = '0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    cnt_d      = cnt_q;
    if (advance) begin
      en    = '1;
      cnt_d = cnt_q + 1'b1;
      if (i_ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        en[EnPc]   = 1'b0;
        en[EnIfid] = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // State and counters; synchronous reset also clears the sticky timeout flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= resume_state(i_dbg_step_mode);
      ret_q   <= StRun;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc_en       = en[EnPc];
  assign o_ifid_en     = en[EnIfid];
  assign o_idex_en     = en[EnIdex];
  assign o_exmem_en    = en[EnExmem];
  assign o_memwb_en    = en[EnMemwb];
  assign o_ifid_flush  = ifid_flush;
  assign o_idex_flush  = idex_flush;
  assign o_dmem_req    = dmem_req;
  assign o_halted      = (state_q == StHalted);
  assign o_err_timeout = err_q;
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Bench for pipeline_ctrl_unit: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_pipeline_ctrl_unit;

  localparam int unsigned RBITS   = 5;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CBITS   = 32;

  // Model modes
  localparam int M_RUN  = 0;
  localparam int M_IDLE = 1;
  localparam int M_STEP = 2;
  localparam int M_WAIT = 3;
  localparam int M_HALT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [RBITS-1:0] id_rs, id_rt, ex_rt;
  logic             ex_memread, br, mem_rd, mem_wr, ack, wb_halt;
  logic             step_mode, dbg_step, resume;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
  logic             dmem_req, halted, err_to;
  logic [CBITS-1:0] cycle_count;

  pipeline_ctrl_unit #(
    .RBITS  (RBITS),
    .TIMEOUT(TIMEOUT),
    .CBITS  (CBITS)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_ex_rt           (ex_rt),
    .i_ex_memread      (ex_memread),
    .i_ex_branch_taken (br),
    .i_mem_memread     (mem_rd),
    .i_mem_memwrite    (mem_wr),
    .i_dmem_ack        (ack),
    .i_wb_halt         (wb_halt),
    .i_dbg_step_mode   (step_mode),
    .i_dbg_step        (dbg_step),
    .i_dbg_resume      (resume),
    .o_pc_en           (pc_en),
    .o_ifid_en         (ifid_en),
    .o_ifid_flush      (ifid_flush),
    .o_idex_en         (idex_en),
    .o_idex_flush      (idex_flush),
    .o_exmem_en        (exmem_en),
    .o_memwb_en        (memwb_en),
    .o_dmem_req        (dmem_req),
    .o_halted          (halted),
    .o_err_timeout     (err_to),
    .o_cycle_count     (cycle_count)
  );

  int tests = 0;
  int fails = 0;
  int en_cycles = 0;
  int now = 0;

  // Model state: mode, where a stall returns to, when the stall began
  int               m_mode, m_ret, m_since;
  bit               m_err;
  logic [CBITS-1:0] m_cnt;
  int               n_mode, n_ret, n_since;
  bit               n_err;
  logic [CBITS-1:0] n_cnt;
  logic [8:0]       e_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected strobes and next model state from the current inputs
  task automatic model_eval();
    bit mem, dep, moves, e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exmem, e_memwb, e_req;
    int waited;
    mem = mem_rd || mem_wr;
    dep = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    moves = 0; e_req = 0;
    {e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exmem, e_memwb} = '0;
    n_mode = m_mode; n_ret = m_ret; n_since = m_since; n_err = m_err; n_cnt = m_cnt;
    if (rst) begin
      n_mode = step_mode ? M_IDLE : M_RUN;
      n_err  = 0;
      n_cnt  = '0;
    end else if (m_mode == M_RUN || m_mode == M_STEP) begin
      e_req = mem;
      if (mem && !ack) begin
        n_mode  = M_WAIT;
        n_ret   = (m_mode == M_RUN) ? M_RUN : M_IDLE;
        n_since = now;
      end else begin
        moves  = 1;
        n_mode = wb_halt ? M_HALT : ((m_mode == M_STEP || step_mode) ? M_IDLE : M_RUN);
      end
    end else if (m_mode == M_WAIT) begin
      e_req  = 1;
      waited = now - m_since;
      if (ack) begin
        moves  = 1;
        n_mode = wb_halt ? M_HALT : m_ret;
      end else if (waited >= int'(TIMEOUT)) begin
        n_err  = 1;
        n_mode = M_HALT;
      end
    end else if (m_mode == M_IDLE) begin
      if (!step_mode) n_mode = M_RUN;
      else if (dbg_step) n_mode = M_STEP;
    end else begin
      if (resume) n_mode = step_mode ? M_IDLE : M_RUN;
    end
    if (moves) begin
      n_cnt = m_cnt + 1;
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = 5'b11111;
      if (br) begin
        e_ifidf = 1; e_idexf = 1;
      end else if (dep) begin
        e_pc = 0; e_ifid = 0; e_idexf = 1;
      end
    end
    e_out = {e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exmem, e_memwb, e_req,
             (m_mode == M_HALT)};
  endtask

  task automatic tick(input string tag);
    model_eval();
    @(negedge clk);
    check({tag, ".outs"}, 64'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                               memwb_en, dmem_req, halted}), 64'(e_out));
    check({tag, ".cnt"}, 64'(cycle_count), 64'(m_cnt));
    check({tag, ".err"}, 64'(err_to), 64'(m_err));
    if (memwb_en === 1'b1) en_cycles++;
    @(posedge clk);
    #1;
    m_mode = n_mode; m_ret = n_ret; m_since = n_since; m_err = n_err; m_cnt = n_cnt;
    now++;
  endtask

  initial begin
    logic [CBITS-1:0] c0;
    rst = 1; id_rs = '0; id_rt = '0; ex_rt = '0; ex_memread = 0; br = 0;
    mem_rd = 0; mem_wr = 0; ack = 0; wb_halt = 0; step_mode = 0; dbg_step = 0; resume = 0;
    repeat (2) @(posedge clk);
    #1;
    m_mode = M_RUN; m_ret = M_RUN; m_since = 0; m_err = 0; m_cnt = '0;
    tick("reset");
    rst = 0;

    // Load-use bubble
    ex_memread = 1; ex_rt = 5; id_rs = 5; #1;
    check("lu.pc_en", pc_en, 0);
    check("lu.ifid_en", ifid_en, 0);
    check("lu.idex_flush", idex_flush, 1);
    check("lu.exmem_en", exmem_en, 1);
    tick("lu");
    ex_rt = 0; #1;
    check("lu_r0.pc_en", pc_en, 1);
    check("lu_r0.idex_flush", idex_flush, 0);
    tick("lu_r0");

    // Branch overrides load-use
    ex_rt = 5; br = 1; #1;
    check("br_lu.pc_en", pc_en, 1);
    check("br_lu.ifid_flush", ifid_flush, 1);
    check("br_lu.idex_flush", idex_flush, 1);
    tick("br_lu");
    br = 0; ex_memread = 0; ex_rt = 0; id_rs = 0;

    // Store with ack three cycles late
    c0 = m_cnt; mem_wr = 1; ack = 0; en_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ack = 1;
      #1;
      check("mw.req", dmem_req, 1);
      tick("mw");
    end
    mem_wr = 0; ack = 0; #1;
    check("mw.en_cycles", en_cycles, 1);
    check("mw.cnt_delta", cycle_count - c0, 1);

    // Timeout halt, then resume keeps the sticky flag
    mem_rd = 1;
    repeat (5) tick("to");
    #1;
    check("to.halted", halted, 1);
    check("to.err", err_to, 1);
    check("to.req", dmem_req, 0);
    resume = 1;
    tick("resume");
    resume = 0; mem_rd = 0; #1;
    check("resume.halted", halted, 0);
    check("resume.err", err_to, 1);
    check("resume.pc_en", pc_en, 1);

    // Single-step: three spaced pulses
    rst = 1; step_mode = 1;
    tick("rst_step");
    rst = 0; en_cycles = 0; #1;
    check("idle.pc_en", pc_en, 0);
    for (int p = 0; p < 3; p++) begin
      dbg_step = 1;
      tick("step");
      dbg_step = 0;
      repeat (4) tick("step_gap");
    end
    check("step.en_cycles", en_cycles, 3);
    check("step.cnt", cycle_count, 3);

    // Step that meets a two-cycle memory wait
    dbg_step = 1;
    tick("stepmw");
    dbg_step = 0; mem_wr = 1;
    tick("stepmw_stall");
    tick("stepmw_w1");
    ack = 1;
    tick("stepmw_w2");
    ack = 0; #1;
    check("stepmw.idle_pc", pc_en, 0);
    check("stepmw.idle_req", dmem_req, 0);
    check("stepmw.cnt", cycle_count, 4);
    mem_wr = 0;

    // Halt from WB
    step_mode = 0;
    tick("to_run");
    wb_halt = 1; #1;
    check("halt.memwb_en", memwb_en, 1);
    tick("halt");
    wb_halt = 0; #1;
    check("halt.halted", halted, 1);
    check("halt.pc_en", pc_en, 0);
    repeat (2) tick("halted");
    resume = 1;
    tick("halt_resume");
    resume = 0;

    // Reset in the middle of a memory wait
    mem_wr = 1;
    tick("rmw_stall");
    tick("rmw_w1");
    rst = 1; #1;
    check("rmw.req", dmem_req, 0);
    check("rmw.pc_en", pc_en, 0);
    tick("rmw_rst");
    rst = 0; mem_wr = 0; #1;
    check("rmw.cnt", cycle_count, 0);
    check("rmw.err", err_to, 0);
    check("rmw.pc_en", pc_en, 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(99) == 0);
      id_rs      = RBITS'($urandom_range(3));
      id_rt      = RBITS'($urandom_range(3));
      ex_rt      = RBITS'($urandom_range(3));
      ex_memread = ($urandom_range(2) == 0);
      br         = ($urandom_range(4) == 0);
      mem_rd     = ($urandom_range(5) == 0);
      mem_wr     = ($urandom_range(7) == 0);
      ack        = ($urandom_range(2) == 0);
      wb_halt    = ($urandom_range(24) == 0);
      dbg_step   = ($urandom_range(3) == 0);
      resume     = ($urandom_range(5) == 0);
      if ($urandom_range(39) == 0) step_mode = ~step_mode;
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl_unit.md
Name: pipeline_ctrl_unit

Overview:
Sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It generates per-stage enable and flush strobes from four sources: load-use hazards, taken branches, data-memory wait states (req/ack handshake) and debug run/step/halt control. It sits beside the datapath and drives the enable/flush inputs of every pipeline register.

Parameters:
RBITS, 5, register-specifier width
TIMEOUT, 255, maximum number of MEM_WAIT cycles before the error halt
CBITS, 32, cycle-counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_id_rs  in  RBITS  rs specifier of the instruction in ID
i_id_rt  in  RBITS  rt specifier of the instruction in ID
i_ex_rt  in  RBITS  destination (rt) of the instruction in EX
i_ex_memread  in  1  instruction in EX is a load
i_ex_branch_taken  in  1  branch or jump resolved taken in EX
i_mem_memread  in  1  MEM-stage load
i_mem_memwrite  in  1  MEM-stage store
i_dmem_ack  in  1  data memory completes the access
i_wb_halt  in  1  HALT instruction is in WB
i_dbg_step_mode  in  1  1 = single-step, 0 = free run
i_dbg_step  in  1  one-cycle pulse: advance one clock
i_dbg_resume  in  1  leave HALTED and go to RUN or IDLE
o_pc_en  out  1  PC load enable
o_ifid_en  out  1  IF/ID enable
o_ifid_flush  out  1  IF/ID clear
o_idex_en  out  1  ID/EX enable
o_idex_flush  out  1  ID/EX clear (bubble)
o_exmem_en  out  1  EX/MEM enable
o_memwb_en  out  1  MEM/WB enable
o_dmem_req  out  1  data-memory request
o_halted  out  1  controller is in HALTED
o_err_timeout  out  1  sticky memory-timeout flag
o_cycle_count  out  CBITS  count of advancing cycles

Behaviour:
- State encoding is 3 bits: RUN, IDLE, STEP, MEM_WAIT, HALTED. The state register, wait counter, return-state register, o_err_timeout and o_cycle_count are registered. All other outputs are combinational from the state and inputs.
- Reset, synchronous and highest priority:
  - State goes to RUN if i_dbg_step_mode=1 is not set, otherwise IDLE.
  - o_cycle_count=0, o_err_timeout=0, wait counter=0.
  - While i_rst is high, every enable, flush and o_dmem_req is 0.
  - Reset during MEM_WAIT drops o_dmem_req the same cycle.
- "Advance cycle": the state is RUN or STEP and no memory stall is present.
  - Base values: all enables 1, flushes 0.
  - Load-use: i_ex_memread & i_ex_rt!=0 & (i_ex_rt==i_id_rs | i_ex_rt==i_id_rt).
    - o_pc_en=0, o_ifid_en=0, o_idex_flush=1.
    - EX/MEM and MEM/WB stay enabled.
  - Branch: i_ex_branch_taken gives o_ifid_flush=1 and o_idex_flush=1, with o_pc_en=1.
    - Branch overrides load-use if both are asserted.
  - o_cycle_count increments by 1 and wraps modulo 2^CBITS.
- Memory handshake:
  - In RUN or STEP, (i_mem_memread|i_mem_memwrite) asserts o_dmem_req in the same cycle.
  - If i_dmem_ack is also high, the cycle advances normally with zero extra latency.
  - Otherwise:
    - All enables are 0 and flushes 0.
    - Return state is saved: RUN→RUN, STEP→IDLE.
    - Next state is MEM_WAIT.
  - In MEM_WAIT:
    - o_dmem_req=1 and all enables are 0.
    - The wait counter increments each cycle.
    - On i_dmem_ack: enables are 1 for this cycle (the access completes), o_cycle_count increments, the wait counter clears, and the next state is the return state.
    - If the counter reaches TIMEOUT without ack: o_err_timeout is set, the next state is HALTED, and o_dmem_req drops.
- Debug:
  - IDLE: all enables 0. i_dbg_step → STEP. Clearing i_dbg_step_mode → RUN.
  - STEP: exactly one advance cycle, then IDLE, or MEM_WAIT then IDLE.
  - RUN: setting i_dbg_step_mode → IDLE at the next edge.
- Halt:
  - i_wb_halt in RUN or STEP: that cycle still advances (MEM/WB captures), then the next state is HALTED.
  - HALTED: all enables 0, o_halted=1, o_cycle_count frozen.
  - i_dbg_resume → RUN or IDLE per i_dbg_step_mode.
  - o_err_timeout clears only on reset.
- Simultaneous events:
  - Priority: reset > memory stall > halt > branch > load-use.
  - i_wb_halt during a memory stall is acted on at the cycle that receives ack.
  - i_dbg_step outside IDLE is ignored.

Decomposition:
- Package pipe_ctrl_pkg: state typedef/localparams (RUN, IDLE, STEP, MEM_WAIT, HALTED) and the enable-vector bit positions.
- Sub-module hazard_detect_unit: purely combinational load-use compare (rs/rt/ex_rt/memread → stall). Instantiated once.
- The FSM, counters and output mux live in the top module.

Test Plan:
- Load-use: i_ex_memread=1, i_ex_rt=5, i_id_rs=5 in RUN → o_pc_en=0, o_ifid_en=0, o_idex_flush=1, o_exmem_en=1 for one cycle. With i_ex_rt=0 → no stall.
- Branch + load-use together: i_ex_branch_taken=1 with the stall condition → o_ifid_flush=1, o_idex_flush=1, o_pc_en=1.
- Memory wait: store in MEM, ack delayed 3 cycles → o_dmem_req high 4 cycles, enables 0 for 3 cycles then 1. o_cycle_count advances by 1, not 4.
- Timeout: TIMEOUT=4, no ack → HALTED after 4 wait cycles, o_err_timeout=1, o_dmem_req=0. i_dbg_resume → RUN, with o_err_timeout still 1.
- Single-step: step_mode=1, three i_dbg_step pulses spaced 5 cycles apart → exactly 3 cycles with enables=1, o_cycle_count=3. A step hitting a 2-cycle memory wait returns to IDLE.
- Halt and reset: i_wb_halt in RUN → one final advance, then o_halted=1. i_rst mid-MEM_WAIT → o_dmem_req=0 the same cycle, state RUN, counters 0.
